sram_arbiter: RTL

Two-port arbiter and sequencer in front of the single-port 64 KiB byte-addressed `sram`, sharing it between the instruction-fetch port (IF) and the load/store data port (D). It grants one transaction at a time, round-robin on conflict. It performs byte/halfword loads with sign/zero extension. Sub-word stores are done as a read-modify-write sequence, since the SRAM only writes 4-byte windows.

---
 rtl/sram_arbiter_pkg.sv | 31 +++
 rtl/sram_arbiter_load_extend.sv | 23 ++
 rtl/sram_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM arbiter: access sizes, FSM states, port IDs.
// Also provides the access-size-to-byte-count helper used by the range check.
package sram_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESP   = 2'd1,
    ST_RMW_WR = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  // The illegal size still maps to 4 bytes; it is rejected separately.
  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: access_bytes = 3'd1;
      SZ_HALF: access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/sram_arbiter_load_extend.sv
// Load data formatter: picks byte/half/word from the low end of a read word
// and sign- or zero-extends it. Shared with the cache fill path.
module load_extend
  import sram_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{(DATA_W-8){!i_unsigned && i_rdata[7]}}, i_rdata[7:0]};
      SZ_HALF: o_data = {{(DATA_W-16){!i_unsigned && i_rdata[15]}}, i_rdata[15:0]};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between the fetch (IF) and load/store (D) ports.
// One transaction at a time, round-robin on conflict, RMW for sub-word stores.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  output logic              if_resp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              d_resp_err,
  output logic              sram_enable,
  output logic              sram_wr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output state_t            dbg_state
);

  // Handshake: a request transfers in the cycle where *_req_valid and
  // *_req_ready are both high; ready is only ever high in IDLE for the
  // port that wins arbitration, and responses cannot be stalled.

  state_t            r_state;
  state_t            w_state_nxt;
  port_t             r_last_grant;
  port_t             r_port;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [15:0]       r_wdata;

  logic              w_if_sel;
  logic              w_d_sel;
  logic              w_grant;
  port_t             w_g_port;
  logic [ADDR_W-1:0] w_g_addr;
  logic              w_g_wr;
  logic [1:0]        w_g_size;
  logic [ADDR_W:0]   w_g_end;
  logic              w_g_err;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merge;

  assign dbg_state = r_state;

  // IF wins when it is alone or when D won the previous grant.
  assign w_if_sel = (r_state == ST_IDLE) && if_req_valid &&
                    (!d_req_valid || (r_last_grant == PORT_D));
  assign w_d_sel  = (r_state == ST_IDLE) && d_req_valid && !w_if_sel;
  assign w_grant  = w_if_sel || w_d_sel;

  assign w_g_port = w_if_sel ? PORT_IF : PORT_D;
  assign w_g_addr = w_if_sel ? if_addr : d_addr;
  assign w_g_wr   = w_d_sel && d_wr;
  assign w_g_size = w_if_sel ? SZ_WORD : d_size;
  assign w_g_end  = {1'b0, w_g_addr} + (ADDR_W+1)'(access_bytes(w_g_size));
  assign w_g_err  = (w_g_size == SZ_BAD) || (w_g_end > {1'b1, {ADDR_W{1'b0}}});

  // The read window starts at the access address, so new data sits at the low end.
  assign w_merge = (r_size == SZ_BYTE) ? {sram_rdata[DATA_W-1:8],  r_wdata[7:0]}
                                       : {sram_rdata[DATA_W-1:16], r_wdata[15:0]};

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .i_rdata    (sram_rdata),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_data     (w_load_data)
  );

  always_comb begin
    w_state_nxt   = r_state;
    if_req_ready  = 1'b0;
    d_req_ready   = 1'b0;
    if_resp_valid = 1'b0;
    if_resp_data  = '0;
    if_resp_err   = 1'b0;
    d_resp_valid  = 1'b0;
    d_resp_data   = '0;
    d_resp_err    = 1'b0;
    sram_enable   = 1'b0;
    sram_wr       = 1'b0;
    sram_addr     = '0;
    sram_wdata    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          if_req_ready = w_if_sel;
          d_req_ready  = w_d_sel;
          if (w_g_err) begin
            w_state_nxt = ST_ERR;
          end else begin
            sram_enable = 1'b1;
            sram_addr   = w_g_addr;
            if (w_g_wr && (w_g_size == SZ_WORD)) begin
              sram_wr     = 1'b1;
              sram_wdata  = d_wdata;
              w_state_nxt = ST_RESP;
            end else if (w_g_wr) begin
              w_state_nxt = ST_RMW_WR;
            end else begin
              w_state_nxt = ST_RESP;
            end
          end
        end
      end
      ST_RMW_WR: begin
        sram_enable = 1'b1;
        sram_wr     = 1'b1;
        sram_addr   = r_addr;
        sram_wdata  = w_merge;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (r_port == PORT_IF) begin
          if_resp_valid = 1'b1;
          if_resp_data  = sram_rdata;
        end else begin
          d_resp_valid = 1'b1;
          d_resp_data  = r_wr ? '0 : w_load_data;
        end
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        if (r_port == PORT_IF) begin
          if_resp_valid = 1'b1;
          if_resp_err   = 1'b1;
        end else begin
          d_resp_valid = 1'b1;
          d_resp_err   = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A reset cycle must never touch memory or handshake with a requester.
    if (rst) begin
      if_req_ready  = 1'b0;
      d_req_ready   = 1'b0;
      if_resp_valid = 1'b0;
      if_resp_data  = '0;
      if_resp_err   = 1'b0;
      d_resp_valid  = 1'b0;
      d_resp_data   = '0;
      d_resp_err    = 1'b0;
      sram_enable   = 1'b0;
      sram_wr       = 1'b0;
      sram_addr     = '0;
      sram_wdata    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= PORT_D;
      r_port       <= PORT_IF;
      r_addr       <= '0;
      r_wr         <= 1'b0;
      r_size       <= SZ_WORD;
      r_unsigned   <= 1'b0;
      r_wdata      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last_grant <= w_g_port;
        r_port       <= w_g_port;
        r_addr       <= w_g_addr;
        r_wr         <= w_g_wr;
        r_size       <= w_g_size;
        r_unsigned   <= d_unsigned;
        r_wdata      <= d_wdata[15:0];
      end
    end
  end

endmodule
